// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data-memory responder for the CPU data port
// Optional misaligned-access check: define DATA_MEM_RESP_ALIGN_CHECK_EN.
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [3:0]        cnt;
   logic [3:0]        cnt_nxt;
   logic              capture;
   logic              enter_resp;

   logic              cap_write;
   logic [IDX_W-1:0]  cap_idx;
   logic [31:0]       cap_wdata;

   logic [IDX_W-1:0]  req_idx;
   logic              ent_write;
   logic [IDX_W-1:0]  ent_idx;
   logic [31:0]       ent_wdata;
   logic              ent_mis;

   logic [31:0]       mem [DEPTH];

   // Word index wraps modulo DEPTH; byte-offset bits are dropped here.
   function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-3:0] w);
      return IDX_W'(32'(w) % DEPTH);
   endfunction

   assign req_idx    = word_index(req_addr[ADDR_WIDTH-1:2]);
   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_RESP);

   // With zero wait states RESP is entered on the acceptance edge itself,
   // so the entry operands come straight from the request port.
   assign ent_write = (state == S_IDLE) ? req_write : cap_write;
   assign ent_idx   = (state == S_IDLE) ? req_idx   : cap_idx;
   assign ent_wdata = (state == S_IDLE) ? req_wdata : cap_wdata;

`ifdef DATA_MEM_RESP_ALIGN_CHECK_EN
   logic req_mis;
   logic cap_mis;
   logic error_q;

   assign req_mis    = (req_addr[1:0] != 2'b00);
   assign ent_mis    = (state == S_IDLE) ? req_mis : cap_mis;
   assign resp_error = error_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_mis <= 1'b0;
         error_q <= 1'b0;
      end else begin
         if (capture) begin
            cap_mis <= req_mis;
         end
         if (enter_resp) begin
            error_q <= ent_mis;
         end
      end
   end
`else
   logic unused_addr_lsbs;

   assign unused_addr_lsbs = ^req_addr[1:0];
   assign ent_mis          = 1'b0;
   assign resp_error       = 1'b0;
`endif

   always_comb begin
      next_state = state;
      cnt_nxt    = cnt;
      capture    = 1'b0;
      enter_resp = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               capture = 1'b1;
               cnt_nxt = WAIT_INIT;
               if (WAIT_INIT == 4'd0) begin
                  next_state = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  next_state = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               next_state = S_RESP;
               enter_resp = 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         cap_write  <= 1'b0;
         cap_idx    <= '0;
         cap_wdata  <= 32'd0;
         resp_rdata <= 32'd0;
      end else begin
         state <= next_state;
         cnt   <= cnt_nxt;
         if (capture) begin
            cap_write <= req_write;
            cap_idx   <= req_idx;
            cap_wdata <= req_wdata;
         end
         if (enter_resp) begin
            resp_rdata <= (ent_write || ent_mis) ? 32'd0 : mem[ent_idx];
         end
      end
   end

   // Storage is deliberately not reset; a store commits only on RESP entry,
   // so a reset during WAIT leaves the array untouched.
   always_ff @(posedge clk) begin
      if (enter_resp && ent_write && !ent_mis) begin
         mem[ent_idx] <= ent_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench; index 0 = WAIT_CYCLES 2, index 1 = WAIT_CYCLES 0 with DEPTH 128
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_write;
   logic [1:0]       resp_ready;
   logic [1:0][9:0]  req_addr;
   logic [1:0][31:0] req_wdata;
   wire  [1:0]       req_ready;
   wire  [1:0]       resp_valid;
   wire  [1:0]       resp_error;
   wire  [1:0][31:0] resp_rdata;

   int vectors     = 0;
   int miscompares = 0;

   data_mem_responder #(.ADDR_WIDTH(10), .DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
   );

   data_mem_responder #(.ADDR_WIDTH(10), .DEPTH(128), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full transaction: issue, measure latency, check response, handshake.
   task automatic xact(input int d, input logic wr, input logic [9:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
      int lat;
      @(negedge clk);
      chk("ready_before_req", 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      lat = 1;
      while (resp_valid[d] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), (d == 0) ? 32'd3 : 32'd1);
      chk("resp_rdata", resp_rdata[d], exp_rd);
      chk("resp_error", 32'(resp_error[d]), 32'(exp_err));
      chk("ready_in_resp", 32'(req_ready[d]), 32'd0);
      resp_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready[d] = 1'b0;
      chk("valid_after_hs", 32'(resp_valid[d]), 32'd0);
      chk("ready_after_hs", 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      int accepts;
      int lat;
      reset      = 1'b1;
      req_valid  = '0;
      req_write  = '0;
      resp_ready = '0;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
         chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
         chk("rst_resp_rdata", resp_rdata[0], 32'd0);
         chk("rst_resp_error", 32'(resp_error[0]), 32'd0);
      end

      // Store then load, 2 wait states
      xact(0, 1'b1, 10'h010, 32'hDEADBEEF, 32'd0, 1'b0);
      xact(0, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);

      // Zero wait states, last word, then alias through wrap (DEPTH 128)
      xact(1, 1'b1, 10'h3FC, 32'h12345678, 32'd0, 1'b0);
      xact(1, 1'b0, 10'h3FC, 32'h0, 32'h12345678, 1'b0);
      xact(1, 1'b0, 10'h1FC, 32'h0, 32'h12345678, 1'b0);

      // Back-to-back loads with both valid and ready held high
      @(negedge clk);
      req_valid[1]  = 1'b1;
      req_write[1]  = 1'b0;
      req_addr[1]   = 10'h3FC;
      resp_ready[1] = 1'b1;
      accepts = 0;
      for (int i = 0; i < 10; i++) begin
         if (req_ready[1] === 1'b1) accepts++;
         if (resp_valid[1] === 1'b1) chk("b2b_rdata", resp_rdata[1], 32'h12345678);
         @(negedge clk);
      end
      req_valid[1] = 1'b0;
      chk("b2b_accepts", 32'(accepts), 32'd5);
      @(posedge clk);
      @(negedge clk);
      resp_ready[1] = 1'b0;

      // Response stall with a competing request held on the port
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      req_addr[0]  = 10'h010;
      @(posedge clk);
      @(negedge clk);
      req_addr[0] = 10'h3FC;
      lat = 1;
      while (resp_valid[0] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("stall_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(resp_valid[0]), 32'd1);
         chk("stall_rdata", resp_rdata[0], 32'hDEADBEEF);
         chk("stall_ready", 32'(req_ready[0]), 32'd0);
         @(negedge clk);
      end
      resp_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready[0] = 1'b0;
      chk("stall_done_valid", 32'(resp_valid[0]), 32'd0);
      chk("stall_no_accept", 32'(req_ready[0]), 32'd1);
      req_valid[0] = 1'b0;

      // Reset during WAIT aborts the store
      xact(0, 1'b1, 10'h020, 32'h11111111, 32'd0, 1'b0);
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 10'h020;
      req_wdata[0] = 32'hAAAA5555;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      chk("in_wait_ready", 32'(req_ready[0]), 32'd0);
      reset = 1'b1;
      #1;
      chk("abort_ready", 32'(req_ready[0]), 32'd1);
      chk("abort_valid", 32'(resp_valid[0]), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      xact(0, 1'b0, 10'h020, 32'h0, 32'h11111111, 1'b0);

      // Misaligned store
      xact(0, 1'b1, 10'h020, 32'h00000000, 32'd0, 1'b0);
`ifdef DATA_MEM_RESP_ALIGN_CHECK_EN
      xact(0, 1'b1, 10'h022, 32'hFFFFFFFF, 32'd0, 1'b1);
      xact(0, 1'b0, 10'h020, 32'h0, 32'h00000000, 1'b0);
`else
      xact(0, 1'b1, 10'h022, 32'hFFFFFFFF, 32'd0, 1'b0);
      xact(0, 1'b0, 10'h020, 32'h0, 32'hFFFFFFFF, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
